// File: rtl/reg_bank_8x16_pkg.sv
// rtl/reg_bank_8x16_pkg.sv - shared constants and types for the 8x16 register bank
package reg_bank_8x16_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;
    localparam int DATA_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    localparam logic [1:0] BE_ALL = 2'b11;

endpackage

// File: rtl/reg_bank_8x16_scoreboard.sv
// rtl/reg_bank_8x16_scoreboard.sv - per-register load-pending scoreboard with hazard lookups
module reg_bank_8x16_scoreboard
    import reg_bank_8x16_pkg::*;
#(
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pend_set,
    input  logic [REG_ADDR_W-1:0] pend_addr,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr_a,
    input  logic [REG_ADDR_W-1:0] chk_addr_b,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  busy_a,
    output logic                  busy_b
);

    logic [NUM_REGS-1:0] pending_next;

    // Set beats clear: a new load may be issued in the cycle the older one retires.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (pend_set && pend_addr == reg_idx_t'(i) && !(ZERO_REG != 0 && i == 0)) begin
                pending_next[i] = 1'b1;
            end else if (wr_en && wr_addr == reg_idx_t'(i)) begin
                pending_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign busy_a = pending[chk_addr_a];
    assign busy_b = pending[chk_addr_b];

endmodule

// File: rtl/reg_bank_8x16.sv
// rtl/reg_bank_8x16.sv - eight 16-bit registers with byte-enabled write and load scoreboard
module reg_bank_8x16
    import reg_bank_8x16_pkg::NUM_REGS;
    import reg_bank_8x16_pkg::REG_ADDR_W;
#(
    parameter int                  DATA_W    = reg_bank_8x16_pkg::DATA_W,
    parameter int                  ZERO_REG  = 1,
    parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [1:0]            wr_be,
    input  logic                  pend_set,
    input  logic [REG_ADDR_W-1:0] pend_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr_a,
    input  logic [REG_ADDR_W-1:0] chk_addr_b,
    output logic [DATA_W-1:0]     r0,
    output logic [DATA_W-1:0]     r1,
    output logic [DATA_W-1:0]     r2,
    output logic [DATA_W-1:0]     r3,
    output logic [DATA_W-1:0]     r4,
    output logic [DATA_W-1:0]     r5,
    output logic [DATA_W-1:0]     r6,
    output logic [DATA_W-1:0]     r7,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  stall
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_allowed;

    assign wr_allowed = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (ZERO_REG != 0 && i == 0) ? '0 : RESET_VAL;
            end
        end else if (wr_allowed) begin
            if (wr_be[0]) regs[wr_addr][7:0]        <= wr_data[7:0];
            if (wr_be[1]) regs[wr_addr][DATA_W-1:8] <= wr_data[DATA_W-1:8];
        end
    end

    // No bypass: the downstream mux sees the pre-write value during the write cycle.
    assign r0 = (ZERO_REG != 0) ? '0 : regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

    reg_bank_8x16_scoreboard #(
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .pend_set   (pend_set),
        .pend_addr  (pend_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .chk_addr_a (chk_addr_a),
        .chk_addr_b (chk_addr_b),
        .pending    (pending),
        .busy_a     (busy_a),
        .busy_b     (busy_b)
    );

    assign stall = busy_a | busy_b;

endmodule

// File: tb/tb_reg_bank_8x16.sv
// tb/tb_reg_bank_8x16.sv - self-checking bench for reg_bank_8x16
module tb_reg_bank_8x16;
    import reg_bank_8x16_pkg::*;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        pend_set = 1'b0;
    logic [2:0]  pend_addr = '0;
    logic [2:0]  chk_addr_a = '0;
    logic [2:0]  chk_addr_b = '0;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0]  pending;
    logic        busy_a, busy_b, stall;

    logic [15:0] r [8];
    assign r[0] = r0; assign r[1] = r1; assign r[2] = r2; assign r[3] = r3;
    assign r[4] = r4; assign r[5] = r5; assign r[6] = r6; assign r[7] = r7;

    reg_bank_8x16 dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .pend_set(pend_set), .pend_addr(pend_addr),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .pending(pending), .busy_a(busy_a), .busy_b(busy_b), .stall(stall)
    );

    always #5 if (clk_en) clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: register file as an array, scoreboard as a bit vector.
    logic [15:0] m_regs [8];
    logic [7:0]  m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_pend = 8'h00;
    endtask

    task automatic model_clock();
        if (wr_en) begin
            if (wr_addr != 3'd0) begin
                if (wr_be[0]) m_regs[wr_addr][7:0]  = wr_data[7:0];
                if (wr_be[1]) m_regs[wr_addr][15:8] = wr_data[15:8];
            end
            m_pend[wr_addr] = 1'b0;
        end
        if (pend_set && pend_addr != 3'd0) m_pend[pend_addr] = 1'b1;
    endtask

    task automatic compare_model(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), 32'(r[i]), 32'(m_regs[i]));
        check({tag, "_pending"}, 32'(pending), 32'(m_pend));
        check({tag, "_busy_a"}, 32'(busy_a), 32'(m_pend[chk_addr_a]));
        check({tag, "_busy_b"}, 32'(busy_b), 32'(m_pend[chk_addr_b]));
        check({tag, "_stall"}, 32'(stall), 32'(m_pend[chk_addr_a] | m_pend[chk_addr_b]));
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [1:0] be, input logic ps, input logic [2:0] pa,
                         input logic [2:0] ca, input logic [2:0] cb);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        pend_set = ps; pend_addr = pa; chk_addr_a = ca; chk_addr_b = cb;
        @(posedge clk);
        if (!rst) model_clock();
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        ps;
        logic [2:0]  pa;
        logic [2:0]  ca;
        logic [2:0]  cb;
        logic [2:0]  ea;
        logic [15:0] ev;
        logic [7:0]  ep;
        logic        eba;
        logic        ebb;
        logic        est;
    } vec_t;

    vec_t vecs [$];

    initial begin
        vecs.push_back('{1, 3, 16'hBEEF, BE_ALL, 0, 0, 0, 0, 3, 16'hBEEF, 8'h00, 0, 0, 0});
        vecs.push_back('{1, 0, 16'h1234, BE_ALL, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0});
        vecs.push_back('{1, 5, 16'hAAAA, BE_ALL, 0, 0, 0, 0, 5, 16'hAAAA, 8'h00, 0, 0, 0});
        vecs.push_back('{1, 5, 16'h1255, 2'b01,  0, 0, 0, 0, 5, 16'hAA55, 8'h00, 0, 0, 0});
        vecs.push_back('{1, 5, 16'h77C3, 2'b10,  0, 0, 0, 0, 5, 16'h7755, 8'h00, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 2'b00,  1, 6, 6, 0, 3, 16'hBEEF, 8'h40, 1, 0, 1});
        vecs.push_back('{1, 6, 16'h6666, BE_ALL, 0, 0, 6, 6, 6, 16'h6666, 8'h00, 0, 0, 0});
        vecs.push_back('{1, 2, 16'h2222, BE_ALL, 1, 2, 2, 0, 2, 16'h2222, 8'h04, 1, 0, 1});
        vecs.push_back('{1, 2, 16'hFFFF, 2'b00,  1, 1, 1, 2, 2, 16'h2222, 8'h02, 1, 0, 1});
        vecs.push_back('{1, 1, 16'h9999, 2'b00,  1, 4, 1, 4, 1, 16'h0000, 8'h10, 0, 1, 1});
        vecs.push_back('{0, 0, 16'h0000, 2'b00,  1, 0, 0, 4, 0, 16'h0000, 8'h10, 0, 1, 1});
        vecs.push_back('{0, 0, 16'h0000, 2'b00,  1, 4, 4, 4, 4, 16'h0000, 8'h10, 1, 1, 1});
        vecs.push_back('{1, 4, 16'h4444, BE_ALL, 0, 0, 4, 4, 4, 16'h4444, 8'h00, 0, 0, 0});
        vecs.push_back('{1, 7, 16'h8001, BE_ALL, 0, 0, 7, 3, 7, 16'h8001, 8'h00, 0, 0, 0});

        // Reset with the clock stopped must act immediately.
        model_reset();
        #1 rst = 1'b1;
        #1;
        compare_model("rst_noclk");
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        compare_model("rst_release");

        foreach (vecs[k]) begin
            drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].be,
                  vecs[k].ps, vecs[k].pa, vecs[k].ca, vecs[k].cb);
            check($sformatf("vec%0d_reg", k), 32'(r[vecs[k].ea]), 32'(vecs[k].ev));
            check($sformatf("vec%0d_pending", k), 32'(pending), 32'(vecs[k].ep));
            check($sformatf("vec%0d_busy_a", k), 32'(busy_a), 32'(vecs[k].eba));
            check($sformatf("vec%0d_busy_b", k), 32'(busy_b), 32'(vecs[k].ebb));
            check($sformatf("vec%0d_stall", k), 32'(stall), 32'(vecs[k].est));
            compare_model($sformatf("vec%0d", k));
        end

        // No bypass: during the write cycle the old value is still visible.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h5A5A; wr_be = BE_ALL; pend_set = 1'b0;
        #1 check("no_bypass_old", 32'(r3), 32'h0000BEEF);
        @(posedge clk);
        model_clock();
        #1 check("no_bypass_new", 32'(r3), 32'h00005A5A);

        // Load up pending = FE, then assert reset between clock edges.
        for (int i = 1; i < 8; i++) drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 3'd7, 3'd1);
        check("pend_fe", 32'(pending), 32'h000000FE);
        check("pend_fe_stall", 32'(stall), 32'h1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hDEAD; wr_be = BE_ALL; pend_set = 1'b1; pend_addr = 3'd5;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midload_pending", 32'(pending), 32'h0);
        check("midload_stall", 32'(stall), 32'h0);
        compare_model("midload");
        @(posedge clk) #1;
        compare_model("rst_held_write");
        @(negedge clk) rst = 1'b0; wr_en = 1'b0; pend_set = 1'b0;
        @(posedge clk) #1;
        compare_model("rst_release2");

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 2'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 3'($urandom));
            compare_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
